// File: rtl/ps2_key_tracker_pkg.sv
// Shared constants and types for the PS/2 Set-2 key tracker.
// Holds the note-key scan codes, the parser state type and a priority encoder.
package ps2_keys_pkg;

    localparam int NUM_KEYS = 18;

    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_ESC   = 8'h76;

    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_W     = 8'h1D;
    localparam logic [7:0] SC_S     = 8'h1B;
    localparam logic [7:0] SC_E     = 8'h24;
    localparam logic [7:0] SC_D     = 8'h23;
    localparam logic [7:0] SC_F     = 8'h2B;
    localparam logic [7:0] SC_T     = 8'h2C;
    localparam logic [7:0] SC_G     = 8'h34;
    localparam logic [7:0] SC_Y     = 8'h35;
    localparam logic [7:0] SC_H     = 8'h33;
    localparam logic [7:0] SC_U     = 8'h3C;
    localparam logic [7:0] SC_J     = 8'h3B;
    localparam logic [7:0] SC_K     = 8'h42;
    localparam logic [7:0] SC_O     = 8'h44;
    localparam logic [7:0] SC_L     = 8'h4B;
    localparam logic [7:0] SC_P     = 8'h4D;
    localparam logic [7:0] SC_SEMI  = 8'h4C;
    localparam logic [7:0] SC_QUOTE = 8'h52;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        BREAK     = 2'd1,
        EXT       = 2'd2,
        EXT_BREAK = 2'd3
    } state_e;

    function automatic logic [4:0] lowest_set(input logic [NUM_KEYS-1:0] v);
        logic [4:0] r;
        r = 5'd0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (v[i]) r = i[4:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/ps2_key_tracker_if.sv
// Bundle between the PS/2 receiver side and the tone/chord consumers.
// The master drives scan bytes; the slave (tracker) drives key state.
interface ps2_key_tracker_if;
    import ps2_keys_pkg::*;

    logic [7:0]          rx_data;
    logic                rx_valid;
    logic [NUM_KEYS-1:0] key_held;
    logic                key_event;
    logic [4:0]          event_idx;
    logic                event_make;
    logic                mono_valid;
    logic [4:0]          mono_idx;
    logic                all_off;
    logic                err_timeout;
    logic [7:0]          last_code;

    modport master (
        output rx_data, rx_valid,
        input  key_held, key_event, event_idx, event_make,
        input  mono_valid, mono_idx, all_off, err_timeout, last_code
    );

    modport slave (
        input  rx_data, rx_valid,
        output key_held, key_event, event_idx, event_make,
        output mono_valid, mono_idx, all_off, err_timeout, last_code
    );

endinterface

// File: rtl/ps2_key_tracker_scan_to_index.sv
// Maps a Set-2 scan code to its note-key index.
// Purely combinational so other keymap users can share it.
module ps2_scan_to_index
    import ps2_keys_pkg::*;
(
    input  logic [7:0] code,
    output logic       hit,
    output logic [4:0] idx
);

    always_comb begin
        hit = 1'b1;
        idx = 5'd0;
        case (code)
            SC_A:     idx = 5'd0;
            SC_W:     idx = 5'd1;
            SC_S:     idx = 5'd2;
            SC_E:     idx = 5'd3;
            SC_D:     idx = 5'd4;
            SC_F:     idx = 5'd5;
            SC_T:     idx = 5'd6;
            SC_G:     idx = 5'd7;
            SC_Y:     idx = 5'd8;
            SC_H:     idx = 5'd9;
            SC_U:     idx = 5'd10;
            SC_J:     idx = 5'd11;
            SC_K:     idx = 5'd12;
            SC_O:     idx = 5'd13;
            SC_L:     idx = 5'd14;
            SC_P:     idx = 5'd15;
            SC_SEMI:  idx = 5'd16;
            SC_QUOTE: idx = 5'd17;
            default:  hit = 1'b0;
        endcase
    end

endmodule

// File: rtl/ps2_key_tracker.sv
// Parses the PS/2 Set-2 byte stream into a polyphonic held-key bitmap,
// per-key press/release events and a mono-mode current key.
module ps2_key_tracker
    import ps2_keys_pkg::*;
#(
    parameter int         TIMEOUT_CYCLES = 2_500_000,
    parameter logic [7:0] PANIC_CODE     = SC_ESC
) (
    input  logic            clk,
    input  logic            reset,
    ps2_key_tracker_if.slave bus
);

    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    state_e              state, state_n;
    logic [TW-1:0]       timer;
    logic [NUM_KEYS-1:0] held, held_n;
    logic [4:0]          newest, newest_n;
    logic                newest_ok, newest_ok_n;
    logic                ev, ev_n;
    logic [4:0]          ev_idx, ev_idx_n;
    logic                ev_make, ev_make_n;
    logic                off, off_n;
    logic                tmo, tmo_n;
    logic [4:0]          mono, mono_n;
    logic [7:0]          code;
    logic                hit;
    logic [4:0]          idx;

    ps2_scan_to_index u_map (
        .code (bus.rx_data),
        .hit  (hit),
        .idx  (idx)
    );

    always_comb begin
        state_n     = state;
        held_n      = held;
        newest_n    = newest;
        newest_ok_n = newest_ok;
        ev_n        = 1'b0;
        ev_idx_n    = ev_idx;
        ev_make_n   = ev_make;
        off_n       = 1'b0;
        tmo_n       = 1'b0;
        if (bus.rx_valid) begin
            if (bus.rx_data == SC_EXT) begin
                state_n = EXT;
            end else if (bus.rx_data == SC_BREAK) begin
                state_n = (state == EXT || state == EXT_BREAK) ? EXT_BREAK : BREAK;
            end else begin
                state_n = IDLE;
                if (state == IDLE) begin
                    if (bus.rx_data == PANIC_CODE) begin
                        held_n = '0;
                        off_n  = 1'b1;
                    end else if (hit && !held[idx]) begin
                        held_n[idx] = 1'b1;
                        ev_n        = 1'b1;
                        ev_idx_n    = idx;
                        ev_make_n   = 1'b1;
                        newest_n    = idx;
                        newest_ok_n = 1'b1;
                    end
                end else if (state == BREAK) begin
                    if (hit && held[idx]) begin
                        held_n[idx] = 1'b0;
                        ev_n        = 1'b1;
                        ev_idx_n    = idx;
                        ev_make_n   = 1'b0;
                    end
                end
            end
        end else if (state != IDLE && timer == TMO_LAST) begin
            state_n = IDLE;
            tmo_n   = 1'b1;
        end
        // a released newest key falls back to the lowest held key
        if (newest_ok_n && held_n[newest_n]) mono_n = newest_n;
        else                                 mono_n = lowest_set(held_n);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            timer     <= '0;
            held      <= '0;
            newest    <= 5'd0;
            newest_ok <= 1'b0;
            ev        <= 1'b0;
            ev_idx    <= 5'd0;
            ev_make   <= 1'b0;
            off       <= 1'b0;
            tmo       <= 1'b0;
            mono      <= 5'd0;
            code      <= 8'd0;
        end else begin
            state     <= state_n;
            held      <= held_n;
            newest    <= newest_n;
            newest_ok <= newest_ok_n;
            ev        <= ev_n;
            ev_idx    <= ev_idx_n;
            ev_make   <= ev_make_n;
            off       <= off_n;
            tmo       <= tmo_n;
            mono      <= mono_n;
            if (bus.rx_valid) code <= bus.rx_data;
            if (bus.rx_valid || state == IDLE) timer <= '0;
            else                               timer <= timer + 1'b1;
        end
    end

    assign bus.key_held    = held;
    assign bus.key_event   = ev;
    assign bus.event_idx   = ev_idx;
    assign bus.event_make  = ev_make;
    assign bus.mono_valid  = |held;
    assign bus.mono_idx    = mono;
    assign bus.all_off     = off;
    assign bus.err_timeout = tmo;
    assign bus.last_code   = code;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Scoreboard bench for ps2_key_tracker: stimulus pushes expected pulses,
// a negedge monitor pops and compares every pulse the DUT emits.
module tb_ps2_key_tracker;
    import ps2_keys_pkg::*;

    localparam int TMO = 16;
    localparam logic [1:0] K_KEY = 2'd0;
    localparam logic [1:0] K_OFF = 2'd1;
    localparam logic [1:0] K_TMO = 2'd2;

    typedef struct packed {
        logic [1:0] kind;
        logic [4:0] idx;
        logic       make;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int total = 0;
    int bad = 0;
    exp_t q[$];

    ps2_key_tracker_if bus ();

    ps2_key_tracker #(.TIMEOUT_CYCLES(TMO), .PANIC_CODE(8'h76)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic push(input logic [1:0] k, input logic [4:0] i, input logic m);
        exp_t e;
        e.kind = k;
        e.idx  = i;
        e.make = m;
        q.push_back(e);
    endtask

    task automatic send(input logic [7:0] b);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    task automatic chk_state(input string name, input logic [17:0] h,
                             input logic mv, input logic [4:0] mi);
        chk({name, ".held"}, 32'(bus.key_held), 32'(h));
        chk({name, ".mono_valid"}, 32'(bus.mono_valid), 32'(mv));
        chk({name, ".mono_idx"}, 32'(bus.mono_idx), 32'(mi));
    endtask

    always @(negedge clk) begin
        if (!reset && (bus.key_event || bus.all_off || bus.err_timeout)) begin
            exp_t e;
            exp_t a;
            a.kind = bus.all_off ? K_OFF : (bus.err_timeout ? K_TMO : K_KEY);
            a.idx  = (a.kind == K_KEY) ? bus.event_idx : 5'd0;
            a.make = (a.kind == K_KEY) ? bus.event_make : 1'b0;
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_pulse: got %0h want none", a);
            end else begin
                e = q.pop_front();
                if (a !== e || (32'(bus.key_event) + 32'(bus.all_off)
                                + 32'(bus.err_timeout)) != 1) begin
                    bad++;
                    $display("FAIL pulse: got kind=%0d idx=%0d make=%0d want kind=%0d idx=%0d make=%0d",
                             a.kind, a.idx, a.make, e.kind, e.idx, e.make);
                end
            end
        end
    end

    initial begin
        int seen;
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk_state("reset", 18'h0, 1'b0, 5'd0);
        chk("reset.last_code", 32'(bus.last_code), 32'h0);
        chk("reset.event_idx", 32'(bus.event_idx), 32'h0);

        push(K_KEY, 5'd0, 1'b1);
        send(SC_A);
        chk_state("make_a", 18'h00001, 1'b1, 5'd0);
        push(K_KEY, 5'd0, 1'b0);
        send(SC_BREAK);
        chk("f0.last_code", 32'(bus.last_code), 32'hF0);
        send(SC_A);
        chk_state("break_a", 18'h0, 1'b0, 5'd0);

        push(K_KEY, 5'd0, 1'b1);
        push(K_KEY, 5'd3, 1'b1);
        push(K_KEY, 5'd7, 1'b1);
        send(SC_A);
        send(SC_E);
        send(SC_G);
        chk_state("chord", 18'h00089, 1'b1, 5'd7);
        push(K_KEY, 5'd7, 1'b0);
        send(SC_BREAK);
        send(SC_G);
        chk_state("chord_rel_g", 18'h00009, 1'b1, 5'd0);
        push(K_KEY, 5'd0, 1'b0);
        push(K_KEY, 5'd3, 1'b0);
        send(SC_BREAK);
        send(SC_A);
        chk_state("chord_rel_a", 18'h00008, 1'b1, 5'd3);
        send(SC_BREAK);
        send(SC_E);
        chk_state("chord_empty", 18'h0, 1'b0, 5'd0);

        push(K_KEY, 5'd0, 1'b1);
        send(SC_A);
        send(SC_A);
        send(SC_A);
        chk_state("typematic", 18'h00001, 1'b1, 5'd0);
        push(K_KEY, 5'd0, 1'b0);
        send(SC_BREAK);
        send(SC_A);
        send(SC_BREAK);
        send(SC_A);
        chk_state("double_break", 18'h0, 1'b0, 5'd0);

        send(SC_EXT);
        send(SC_A);
        send(SC_EXT);
        send(SC_BREAK);
        send(SC_A);
        send(8'hAA);
        send(8'hFA);
        chk_state("ext_unmapped", 18'h0, 1'b0, 5'd0);
        push(K_KEY, 5'd1, 1'b1);
        send(SC_W);
        chk_state("after_ext", 18'h00002, 1'b1, 5'd1);

        push(K_TMO, 5'd0, 1'b0);
        send(SC_BREAK);
        seen = 0;
        for (int i = 1; i <= TMO + 4; i++) begin
            @(negedge clk);
            if (bus.err_timeout && seen == 0) seen = i;
        end
        chk("timeout_cycle", 32'(seen), 32'(TMO));
        chk_state("timeout_held", 18'h00002, 1'b1, 5'd1);
        push(K_KEY, 5'd2, 1'b1);
        send(SC_S);
        chk_state("post_timeout", 18'h00006, 1'b1, 5'd2);

        push(K_KEY, 5'd0, 1'b1);
        push(K_KEY, 5'd17, 1'b1);
        send(SC_A);
        send(SC_QUOTE);
        chk_state("pre_panic", 18'h20007, 1'b1, 5'd17);
        push(K_OFF, 5'd0, 1'b0);
        send(8'h76);
        chk_state("panic", 18'h0, 1'b0, 5'd0);
        send(SC_BREAK);
        send(8'h76);
        chk("panic_break.last_code", 32'(bus.last_code), 32'h76);

        reset        = 1'b1;
        bus.rx_data  = SC_A;
        bus.rx_valid = 1'b1;
        @(negedge clk);
        reset        = 1'b0;
        bus.rx_valid = 1'b0;
        @(negedge clk);
        chk_state("reset_vs_rx", 18'h0, 1'b0, 5'd0);
        chk("reset_vs_rx.last_code", 32'(bus.last_code), 32'h0);

        repeat (4) @(negedge clk);
        chk("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ps2_key_tracker.md
Name: ps2_key_tracker

Overview:
Sits between PS2_Controller and the tone/chord generators. It consumes the raw scan-code byte stream (received_data / received_data_en) and parses PS/2 Set-2 make, break (F0) and extended (E0) sequences. It maintains a polyphonic 18-bit held-key bitmap, replacing the single-key latch, so chords can be played. It also emits per-key press/release events and a mono-mode "current key" index.

Parameters:
NUM_KEYS, 18, width of key_held; fixed by the note map.
TIMEOUT_CYCLES, 2_500_000, clk cycles (50 ms at 50 MHz) a prefix state may wait for its next byte before aborting to IDLE.
PANIC_CODE, 8'h76, scan code (Esc) whose make clears all held keys.

Ports:
clk  in  1  system clock (50 MHz)
reset  in  1  synchronous, active-high
rx_data  in  8  scan-code byte from PS2_Controller
rx_valid  in  1  one-cycle strobe; rx_data valid this cycle
key_held  out  18  bit i = 1 while note key i is held
key_event  out  1  one-cycle pulse when key_held changes for a single key
event_idx  out  5  index of key for key_event
event_make  out  1  1 = press, 0 = release (qualified by key_event)
mono_valid  out  1  = |key_held
mono_idx  out  5  most recently pressed key if still held, else lowest held index; 0 when none held
all_off  out  1  one-cycle pulse on panic clear
err_timeout  out  1  one-cycle pulse on prefix timeout
last_code  out  8  last rx_data accepted, for HEX display

Behaviour:
- One clock; reset is synchronous and active-high. Reset has priority over rx_valid in the same cycle.
- Reset values: state=IDLE; key_held=0; all pulses=0; event_idx=0; event_make=0; mono_idx=0; last_code=0; timer=0; newest register=0 and invalid.
- Key map (index:code): 0:1C A, 1:1D W, 2:1B S, 3:24 E, 4:23 D, 5:2B F, 6:2C T, 7:34 G, 8:35 Y, 9:33 H, 10:3C U, 11:3B J, 12:42 K, 13:44 O, 14:4B L, 15:4D P, 16:4C ;, 17:52 '.
- FSM states: IDLE, BREAK, EXT, EXT_BREAK. Transitions happen on rx_valid only.
  - Any state, rx=E0: go to EXT.
  - IDLE, rx=F0: go to BREAK. EXT, rx=F0: go to EXT_BREAK. BREAK or EXT_BREAK, rx=F0: stay.
  - IDLE, other byte: treat as make, then go to IDLE.
  - BREAK, other byte: treat as break, then go to IDLE.
  - EXT or EXT_BREAK, other byte: discard (extended keys are unmapped), then go to IDLE.
- Make of mapped key i:
  - If not held: set bit i, key_event=1, event_make=1, newest=i.
  - If already held (typematic repeat): no change, no event.
- Break of mapped key i:
  - If held: clear bit i, key_event=1, event_make=0.
  - If not held: no event.
- Unmapped make/break codes (including AA, FA, FE, 00, FF) are consumed with no event.
- Make of PANIC_CODE: key_held=0, all_off=1, no key_event. Break of PANIC_CODE is ignored.
- Latency: rx_valid at cycle N produces updated key_held, pulses, mono outputs and last_code registered at N+1.
- mono_idx is registered:
  - newest is still held: newest.
  - newest not held: priority encode of the lowest set bit of key_held.
- Timeout:
  - timer clears on every rx_valid and in IDLE; increments otherwise.
  - In a non-IDLE state, when timer reaches TIMEOUT_CYCLES-1: go to IDLE, err_timeout=1, key_held unchanged.
- last_code updates on every rx_valid, including F0/E0.

Decomposition:
- Package ps2_keys_pkg holds:
  - NUM_KEYS.
  - Scan-code constants: SC_BREAK=F0, SC_EXT=E0, the 18 note codes, SC_ESC.
  - State enum {IDLE, BREAK, EXT, EXT_BREAK}.
- Sub-module ps2_scan_to_index: combinational rx_data[7:0] → {hit, idx[4:0]}. It is shared with future keymap users.

Test Plan:
- Reset, then send 1C → key_held=0x00001, key_event with idx=0 and make=1 at N+1, mono_idx=0. Then send F0,1C → key_held=0, release event idx=0, mono_valid=0.
- Send 1C,24,34 (A,E,G chord) → key_held=0x00089, three make events, mono_idx=7. Then send F0,34 → key_held=0x00009, mono_idx=0 (lowest held).
- Send 1C three times (typematic) → a single key_event only; key_held=0x00001.
- Send E0,1C and E0,F0,1C → no events, key_held unchanged, state back to IDLE. Then send 1D → bit 1 set.
- Send F0 then idle for TIMEOUT_CYCLES (use a small parameter, e.g. 16) → err_timeout at cycle 16, state IDLE. Then send 1B → treated as make, bit 2 set.
- Hold 1C and 52, then send 76 → key_held=0, all_off pulse. Assert reset in the same cycle as rx_valid with data 1C → key_held stays 0.
